// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: two-requester queued register-file write arbiter with round-robin grant and read hazard flags
module reg_write_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0Valid,
  output logic             req0Ready,
  input  logic [4:0]       req0Addr,
  input  logic [31:0]      req0Data,
  input  logic             req1Valid,
  output logic             req1Ready,
  input  logic [4:0]       req1Addr,
  input  logic [31:0]      req1Data,
  output logic             regWrite,
  output logic [4:0]       writeRegAddr,
  output logic [31:0]      writeData,
  input  logic [4:0]       readReg1Addr,
  input  logic [4:0]       readReg2Addr,
  output logic             reg1Busy,
  output logic             reg2Busy,
  output logic [CNT_W-1:0] collisionCount
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [AW:0] wr_ptr_q [2];
  logic [AW:0] wr_ptr_d [2];
  logic [AW:0] rd_ptr_q [2];
  logic [AW:0] rd_ptr_d [2];
  logic [4:0] addr_q [2][FIFO_DEPTH];
  logic [4:0] addr_d [2][FIFO_DEPTH];
  logic [31:0] data_q [2][FIFO_DEPTH];
  logic [31:0] data_d [2][FIFO_DEPTH];
  logic [AW:0] count [2];
  logic empty [2];
  logic ready [2];
  logic push [2];
  logic pop [2];
  logic valid_in [2];
  logic [4:0] in_addr [2];
  logic [31:0] in_data [2];
  logic both, any, grant;
  logic last_grant_q, last_grant_d;
  logic reg_write_q, reg_write_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0] coll_q, coll_d;
  logic [AW-1:0] off;
  logic hit1, hit2;
  assign valid_in[0] = req0Valid;
  assign valid_in[1] = req1Valid;
  assign in_addr[0] = req0Addr;
  assign in_addr[1] = req1Addr;
  assign in_data[0] = req0Data;
  assign in_data[1] = req1Data;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      count[i] = wr_ptr_q[i] - rd_ptr_q[i];
      empty[i] = count[i] == '0;
      ready[i] = !reset && !count[i][AW];
      push[i] = valid_in[i] && ready[i] && in_addr[i] != 5'd0;
    end
    both = !empty[0] && !empty[1];
    any = !empty[0] || !empty[1];
    grant = both ? !last_grant_q : empty[0];
    addr_d = addr_q;
    data_d = data_q;
    for (int i = 0; i < 2; i++) begin
      pop[i] = any && (grant == 1'(i));
      wr_ptr_d[i] = wr_ptr_q[i] + (AW+1)'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + (AW+1)'(pop[i]);
      if (push[i]) begin
        addr_d[i][wr_ptr_q[i][AW-1:0]] = in_addr[i];
        data_d[i][wr_ptr_q[i][AW-1:0]] = in_data[i];
      end
    end
    last_grant_d = any ? grant : last_grant_q;
    reg_write_d = any;
    wr_addr_d = any ? addr_q[grant][rd_ptr_q[grant][AW-1:0]] : wr_addr_q;
    wr_data_d = any ? data_q[grant][rd_ptr_q[grant][AW-1:0]] : wr_data_q;
    coll_d = coll_q + CNT_W'(both && coll_q != '1);
  end
  // an entry is live when its distance from the read pointer is below the occupancy
  always_comb begin
    hit1 = reg_write_q && wr_addr_q == readReg1Addr;
    hit2 = reg_write_q && wr_addr_q == readReg2Addr;
    off = '0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        off = AW'(k) - rd_ptr_q[i][AW-1:0];
        if ({1'b0, off} < count[i]) begin
          hit1 = hit1 | (addr_q[i][k] == readReg1Addr);
          hit2 = hit2 | (addr_q[i][k] == readReg2Addr);
        end
      end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
      addr_q <= '{default: '{default: '0}};
      data_q <= '{default: '{default: '0}};
      last_grant_q <= 1'b1;
      reg_write_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      coll_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      last_grant_q <= last_grant_d;
      reg_write_q <= reg_write_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      coll_q <= coll_d;
    end
  end
  assign req0Ready = ready[0];
  assign req1Ready = ready[1];
  assign regWrite = reg_write_q;
  assign writeRegAddr = wr_addr_q;
  assign writeData = wr_data_q;
  assign collisionCount = coll_q;
  assign reg1Busy = hit1 && readReg1Addr != 5'd0;
  assign reg2Busy = hit2 && readReg2Addr != 5'd0;
endmodule
